divider_front_end: RTL and testbench

- Upstream request sequencer for the 8-bit bit-slice divider.
- Accepts a dividend/divisor pair from a host over a valid/ready handshake and presents the operands to the datapath.
- Runs a four-phase Req/Done handshake with the divider control unit and captures quotient/remainder.
- Returns the result to the host over a second valid/ready handshake. Handles divide-by-zero locally and guards against a hung control unit with a watchdog.

---
 rtl/divider_front_end.sv | 153 +++++++++++++++
 tb/tb_divider_front_end.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_front_end.sv
// rtl/divider_front_end.sv - host-side request sequencer for the bit-slice divider
//
// Takes a dividend/divisor pair from the host, presents it to the divider
// datapath, runs a four-phase Req/Done handshake with the divider control
// unit, and hands the captured quotient/remainder back to the host.
// Divide-by-zero is answered locally without touching the divider, and a
// watchdog aborts an operation whose control unit never completes.
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   InValid/InReady              host operand handshake
//   InDividend, InDivisor        operands from host
//   Req/Done                     four-phase handshake with divider control
//   OpA, OpB                     operands to datapath, stable while Busy
//   Quotient, Remainder          results from datapath
//   OutValid/OutReady            host result handshake
//   OutQuotient, OutRemainder    captured result
//   OutDivZero, OutTimeout       result came from divide-by-zero / watchdog abort
//   Busy                         high whenever not idle

module divider_front_end #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InDividend,
  input  logic [WIDTH-1:0] InDivisor,
  output logic             Req,
  input  logic             Done,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  input  logic [WIDTH-1:0] Quotient,
  input  logic [WIDTH-1:0] Remainder,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutQuotient,
  output logic [WIDTH-1:0] OutRemainder,
  output logic             OutDivZero,
  output logic             OutTimeout,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    RESULT  = 2'd3
  } stateT;

  localparam int WDW = $clog2(TIMEOUT + 1);
  // Abort fires on the TIMEOUT-th cycle spent in REQ plus RELEASE.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  stateT          state;
  logic [WDW-1:0] watchdog;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      watchdog     <= '0;
      Req          <= 1'b0;
      OutValid     <= 1'b0;
      InReady      <= 1'b1;
      Busy         <= 1'b0;
      OpA          <= '0;
      OpB          <= '0;
      OutQuotient  <= '0;
      OutRemainder <= '0;
      OutDivZero   <= 1'b0;
      OutTimeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Done is deliberately ignored here.
          if (InValid) begin
            OpA     <= InDividend;
            OpB     <= InDivisor;
            InReady <= 1'b0;
            Busy    <= 1'b1;
            if (InDivisor == '0) begin
              // Answered locally; the divider is never requested.
              state        <= RESULT;
              OutQuotient  <= '1;
              OutRemainder <= InDividend;
              OutDivZero   <= 1'b1;
              OutValid     <= 1'b1;
            end else begin
              state <= REQ;
              Req   <= 1'b1;
            end
          end
        end

        REQ: begin
          // Done takes priority over a coincident watchdog expiry.
          if (Done) begin
            OutQuotient  <= Quotient;
            OutRemainder <= Remainder;
            Req          <= 1'b0;
            state        <= RELEASE;
            watchdog     <= watchdog + 1'b1;
          end else if (watchdog == WD_LAST) begin
            Req          <= 1'b0;
            OutQuotient  <= '0;
            OutRemainder <= '0;
            OutTimeout   <= 1'b1;
            OutValid     <= 1'b1;
            state        <= RESULT;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        RELEASE: begin
          // Captured data stay frozen while Done is still high.
          if (!Done) begin
            OutValid <= 1'b1;
            state    <= RESULT;
          end else if (watchdog >= WD_LAST) begin
            // >= because capture on the last REQ cycle already bumped past WD_LAST.
            OutQuotient  <= '0;
            OutRemainder <= '0;
            OutTimeout   <= 1'b1;
            OutValid     <= 1'b1;
            state        <= RESULT;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        RESULT: begin
          if (OutReady) begin
            OutValid   <= 1'b0;
            OutDivZero <= 1'b0;
            OutTimeout <= 1'b0;
            InReady    <= 1'b1;
            Busy       <= 1'b0;
            watchdog   <= '0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_front_end.sv
// tb/tb_divider_front_end.sv - self-checking bench for divider_front_end

module tb_divider_front_end;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 20;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InDividend;
  logic [WIDTH-1:0] InDivisor;
  logic             Req;
  logic             Done;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutQuotient;
  logic [WIDTH-1:0] OutRemainder;
  logic             OutDivZero;
  logic             OutTimeout;
  logic             Busy;

  int checks = 0;
  int errors = 0;

  divider_front_end #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InDividend(InDividend), .InDivisor(InDivisor),
    .Req(Req), .Done(Done),
    .OpA(OpA), .OpB(OpB),
    .Quotient(Quotient), .Remainder(Remainder),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutQuotient(OutQuotient), .OutRemainder(OutRemainder),
    .OutDivZero(OutDivZero), .OutTimeout(OutTimeout),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         delay;  // cycles from Req to Done; -1 = control unit never answers
    int         hold;   // cycles Done stays high
    int         bp;     // cycles of OutReady=0 in RESULT
    bit         late;   // datapath output changes while Done still high
    logic [7:0] expQ;
    logic [7:0] expR;
    bit         expDz;
    bit         expTo;
  } vecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one full transaction; the bench acts as host, divider control and datapath.
  task automatic doOp(input vecT v);
    int n;
    @(negedge Clock);
    chk("in_ready_idle", 32'(InReady), 32'd1);
    InValid = 1'b1; InDividend = v.a; InDivisor = v.b;
    @(negedge Clock);
    InValid = 1'b0;
    if (v.b == 8'd0) begin
      chk("dz_no_req", 32'(Req), 32'd0);
    end else begin
      chk("req_after_accept", 32'(Req), 32'd1);
      if (v.delay < 0) begin
        n = 0;
        while (Req && n < 100) begin
          n++;
          @(negedge Clock);
        end
        chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
      end else begin
        repeat (v.delay) @(negedge Clock);
        chk("req_before_done", 32'(Req), 32'd1);
        Done = 1'b1; Quotient = v.a / v.b; Remainder = v.a % v.b;
        @(negedge Clock);
        chk("req_drop_on_done", 32'(Req), 32'd0);
        if (v.late) begin Quotient = 8'd99; Remainder = 8'd77; end
        repeat (v.hold - 1) begin
          @(negedge Clock);
          chk("no_valid_while_done", 32'(OutValid), 32'd0);
        end
        Done = 1'b0;
        @(negedge Clock);
      end
    end
    chk("out_valid", 32'(OutValid), 32'd1);
    chk("out_quotient", 32'(OutQuotient), 32'(v.expQ));
    chk("out_remainder", 32'(OutRemainder), 32'(v.expR));
    chk("out_divzero", 32'(OutDivZero), 32'(v.expDz));
    chk("out_timeout", 32'(OutTimeout), 32'(v.expTo));
    chk("op_a_stable", 32'(OpA), 32'(v.a));
    chk("op_b_stable", 32'(OpB), 32'(v.b));
    chk("in_ready_result", 32'(InReady), 32'd0);
    chk("busy_result", 32'(Busy), 32'd1);
    chk("req_result", 32'(Req), 32'd0);
    repeat (v.bp) begin
      @(negedge Clock);
      chk("bp_valid_hold", 32'(OutValid), 32'd1);
      chk("bp_quotient_hold", 32'(OutQuotient), 32'(v.expQ));
      chk("bp_remainder_hold", 32'(OutRemainder), 32'(v.expR));
      chk("bp_in_ready", 32'(InReady), 32'd0);
    end
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    chk("valid_clear", 32'(OutValid), 32'd0);
    chk("in_ready_back", 32'(InReady), 32'd1);
    chk("busy_clear", 32'(Busy), 32'd0);
    chk("flags_clear", 32'({OutDivZero, OutTimeout}), 32'd0);
  endtask

  vecT table_[$];
  vecT v;

  initial begin
    Reset = 1'b1; InValid = 1'b0; InDividend = '0; InDivisor = '0;
    Done = 1'b0; Quotient = '0; Remainder = '0; OutReady = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_req", 32'(Req), 32'd0);
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_in_ready", 32'(InReady), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ops", 32'({OpA, OpB}), 32'd0);
    chk("rst_results", 32'({OutQuotient, OutRemainder}), 32'd0);
    chk("rst_flags", 32'({OutDivZero, OutTimeout}), 32'd0);
    Reset = 1'b0;

    // Done in IDLE must have no effect.
    Done = 1'b1;
    repeat (2) @(negedge Clock);
    chk("idle_done_ignored_req", 32'(Req), 32'd0);
    chk("idle_done_ignored_busy", 32'(Busy), 32'd0);
    Done = 1'b0;

    //              a     b   dly hold bp late  q      r     dz  to
    table_.push_back('{8'd100, 8'd7, 10, 2, 0, 0, 8'd14, 8'd2, 0, 0});
    table_.push_back('{8'd200, 8'd0,  0, 0, 0, 0, 8'hFF, 8'd200, 1, 0});
    table_.push_back('{8'd50,  8'd5,  3, 1, 5, 0, 8'd10, 8'd0, 0, 0});
    table_.push_back('{8'd77,  8'd3, -1, 0, 1, 0, 8'd0,  8'd0, 0, 1});
    table_.push_back('{8'd100, 8'd7,  4, 3, 0, 1, 8'd14, 8'd2, 0, 0});
    table_.push_back('{8'd255, 8'd1,  0, 1, 0, 0, 8'd255, 8'd0, 0, 0});
    table_.push_back('{8'd7,   8'd9,  2, 2, 2, 1, 8'd0,  8'd7, 0, 0});
    for (int i = 0; i < table_.size(); i++) doOp(table_[i]);

    // Reset while in REQ drops the operation.
    @(negedge Clock);
    InValid = 1'b1; InDividend = 8'd30; InDivisor = 8'd4;
    @(negedge Clock);
    InValid = 1'b0;
    chk("rst_seq_req_up", 32'(Req), 32'd1);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("rst_seq_req", 32'(Req), 32'd0);
    chk("rst_seq_in_ready", 32'(InReady), 32'd1);
    chk("rst_seq_valid", 32'(OutValid), 32'd0);
    repeat (2) @(negedge Clock);
    chk("rst_seq_no_valid_later", 32'(OutValid), 32'd0);
    doOp('{8'd9, 8'd3, 5, 2, 0, 0, 8'd3, 8'd0, 0, 0});

    // Random operations against a plain-arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      v.a     = 8'($urandom_range(0, 255));
      v.b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      v.delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
      v.hold  = int'($urandom_range(1, 4));
      v.bp    = int'($urandom_range(0, 3));
      v.late  = 1'($urandom_range(0, 1));
      if (v.b == 8'd0) begin
        v.expQ = 8'hFF; v.expR = v.a; v.expDz = 1'b1; v.expTo = 1'b0;
      end else if (v.delay < 0) begin
        v.expQ = 8'd0; v.expR = 8'd0; v.expDz = 1'b0; v.expTo = 1'b1;
      end else begin
        v.expQ = v.a / v.b; v.expR = v.a % v.b; v.expDz = 1'b0; v.expTo = 1'b0;
      end
      doOp(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
